// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory arbiter.
// A block is 8 words of 16 bits, so the beat index fits in 3 bits.
package mem_arb_pkg;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BEAT_W          = 3;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, main memory and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic                         i_req;
  logic [ADDR_W-1:0]            i_addr;
  logic                         d_req;
  logic                         d_wr;
  logic [ADDR_W-1:0]            d_addr;
  logic [DATA_W-1:0]            d_wdata;
  logic                         i_grant;
  logic                         d_grant;
  logic [DATA_W-1:0]            rdata;
  logic                         i_valid;
  logic                         d_valid;
  logic [mem_arb_pkg::BEAT_W-1:0] beat_idx;
  logic                         i_done;
  logic                         d_done;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic                         mem_enable;
  logic                         mem_wr;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         mem_data_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    output i_grant, d_grant, rdata, i_valid, d_valid, beat_idx, i_done, d_done,
           mem_addr, mem_wdata, mem_enable, mem_wr
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    input  i_grant, d_grant, rdata, i_valid, d_valid, beat_idx, i_done, d_done,
           mem_addr, mem_wdata, mem_enable, mem_wr
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on a conflict the requester that was
// not granted last wins. Output is one-hot {D, I}.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  owner_t     last_grant,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    if (i_req && d_req)
      pick = (last_grant == OWN_D) ? 2'b01 : 2'b10;
    else
      pick = {d_req, i_req};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Owns the memory4c port for one cache transaction at a time: an 8-word
// pipelined block fill for either cache, or a single-word D-cache write.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);

  state_t              state, state_nx;
  owner_t              owner, last_grant;
  logic [ADDR_W-1:1]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BEAT_W-1:0]   issue_cnt, ret_cnt;
  logic                issue_done;
  logic [1:0]          pick;
  logic                accept, in_issue, beat, last_beat;

  rr_arb2 u_rr (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_grant (last_grant),
    .pick       (pick)
  );

  assign accept    = (state == IDLE) && (pick != 2'b00);
  assign in_issue  = (state == FILL) && !issue_done;
  assign beat      = (state == FILL) && bus.mem_data_valid;
  assign last_beat = beat && (ret_cnt == LAST_BEAT);
  assign bus.rdata = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Issue and return counters run independently: returns trail issues by the memory latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner      <= OWN_I;
      last_grant <= OWN_D;
      addr_q     <= '0;
      wdata_q    <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issue_done <= 1'b0;
    end else if (accept) begin
      owner      <= pick[1] ? OWN_D : OWN_I;
      last_grant <= pick[1] ? OWN_D : OWN_I;
      addr_q     <= pick[1] ? bus.d_addr[ADDR_W-1:1] : bus.i_addr[ADDR_W-1:1];
      wdata_q    <= bus.d_wdata;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issue_done <= 1'b0;
    end else begin
      if (in_issue) begin
        issue_cnt <= issue_cnt + 1'b1;
        if (issue_cnt == LAST_BEAT) issue_done <= 1'b1;
      end
      if (beat) ret_cnt <= ret_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx       = state;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.i_valid    = 1'b0;
    bus.d_valid    = 1'b0;
    bus.beat_idx   = '0;
    bus.i_done     = 1'b0;
    bus.d_done     = 1'b0;
    bus.i_grant    = (state != IDLE) && (owner == OWN_I);
    bus.d_grant    = (state != IDLE) && (owner == OWN_D);
    case (state)
      IDLE: begin
        if (accept) state_nx = (pick[1] && bus.d_wr) ? WRITE : FILL;
      end
      FILL: begin
        bus.mem_enable = in_issue;
        if (in_issue) bus.mem_addr = {addr_q[ADDR_W-1:4], issue_cnt, 1'b0};
        bus.i_valid = beat && (owner == OWN_I);
        bus.d_valid = beat && (owner == OWN_D);
        if (beat) bus.beat_idx = ret_cnt;
        bus.i_done = last_beat && (owner == OWN_I);
        bus.d_done = last_beat && (owner == OWN_D);
        if (last_beat) state_nx = IDLE;
      end
      WRITE: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = {addr_q, 1'b0};
        bus.mem_wdata  = wdata_q;
        bus.d_done     = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model.
// Each cycle the full output bundle is compared against a hand-built expectation.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic [7:0]  ctl;   // {i_grant,d_grant,mem_enable,mem_wr,i_valid,d_valid,i_done,d_done}
    logic [15:0] addr;
    logic [2:0]  beat;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors    = 0;
  int   miscompares = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: read issued in cycle c returns data (addr ^ A5C3) in cycle c+4.
  logic [3:0]  pv = 4'b0000;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], bus.mem_enable & ~bus.mem_wr};
    pa[0] <= bus.mem_addr;
    for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
  end
  assign bus.mem_data_valid = pv[3];
  assign bus.mem_rdata      = pv[3] ? (pa[3] ^ 16'hA5C3) : 16'h0000;

  function automatic snap_t snap();
    snap_t s;
    s.ctl   = {bus.i_grant, bus.d_grant, bus.mem_enable, bus.mem_wr,
               bus.i_valid, bus.d_valid, bus.i_done, bus.d_done};
    s.addr  = bus.mem_addr;
    s.beat  = bus.beat_idx;
    s.wdata = bus.mem_wdata;
    s.rdata = bus.rdata;
    return s;
  endfunction

  // Expected outputs c cycles after a fill was accepted (latency 4, 8 beats).
  function automatic snap_t exp_fill(input bit d_own, input logic [15:0] base, input int c);
    snap_t e;
    e = '0;
    e.ctl[7] = !d_own;
    e.ctl[6] = d_own;
    e.ctl[5] = (c <= 8);
    if (c <= 8) e.addr = base + 16'(2 * (c - 1));
    if (c >= 5) begin
      e.ctl[3] = !d_own;
      e.ctl[2] = d_own;
      e.beat   = 3'(c - 5);
      e.rdata  = (base + 16'(2 * (c - 5))) ^ 16'hA5C3;
    end
    e.ctl[1] = !d_own && (c == 12);
    e.ctl[0] = d_own && (c == 12);
    return e;
  endfunction

  function automatic snap_t exp_write(input logic [15:0] a, input logic [15:0] d);
    snap_t e;
    e       = '0;
    e.ctl   = 8'b0111_0001;
    e.addr  = a;
    e.wdata = d;
    return e;
  endfunction

  task automatic show_fail(input string name, input int c, input snap_t o, input snap_t e);
    $display("[TB] FAIL %s cyc=%0d got ctl=%b addr=%h beat=%0d wdata=%h rdata=%h required ctl=%b addr=%h beat=%0d wdata=%h rdata=%h",
             name, c, o.ctl, o.addr, o.beat, o.wdata, o.rdata, e.ctl, e.addr, e.beat, e.wdata, e.rdata);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    snap_t o;
    rst_n = 1'b0; bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_wr = 1'b0;
    bus.i_addr = 16'h1111; bus.d_addr = 16'h2222; bus.d_wdata = 16'h3333;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      o = snap(); vectors++;
      if (o !== snap_t'(0)) begin miscompares++; show_fail("reset", c, o, '0); end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    o = snap(); vectors++;
    if (o !== snap_t'(0)) begin miscompares++; show_fail("reset_idle", 3, o, '0); end
  endtask

  task automatic test_i_fill();
    snap_t o, e;
    do_reset();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 16'h1234; #1;
    o = snap(); vectors++;
    if (o !== snap_t'(0)) begin miscompares++; show_fail("i_fill_accept", 0, o, '0); end
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk); #1;
      o = snap(); e = (c <= 12) ? exp_fill(1'b0, 16'h1230, c) : snap_t'(0); vectors++;
      if (o !== e) begin miscompares++; show_fail("i_fill", c, o, e); end
      if (c == 12) bus.i_req = 1'b0;
    end
  endtask

  task automatic test_rr_d_first();
    snap_t o, e;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 16'h2200;
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h3331; bus.d_wdata = 16'h1357; #1;
    o = snap(); vectors++;
    if (o !== snap_t'(0)) begin miscompares++; show_fail("rr_accept", 0, o, '0); end
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk); #1;
      o = snap();
      if (c == 1)       e = exp_write(16'h3330, 16'h1357);
      else if (c == 2)  e = '0;
      else if (c <= 14) e = exp_fill(1'b0, 16'h2200, c - 2);
      else              e = '0;
      vectors++;
      if (o !== e) begin miscompares++; show_fail("rr_d_first", c, o, e); end
      if (c == 1) begin bus.d_req = 1'b0; bus.d_wr = 1'b0; end
      if (c == 14) bus.i_req = 1'b0;
    end
  endtask

  task automatic test_d_write();
    snap_t o, e;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0A07; bus.d_wdata = 16'hBEEF; #1;
    o = snap(); vectors++;
    if (o !== snap_t'(0)) begin miscompares++; show_fail("d_write_accept", 0, o, '0); end
    @(negedge clk); #1;
    o = snap(); e = exp_write(16'h0A06, 16'hBEEF); vectors++;
    if (o !== e) begin miscompares++; show_fail("d_write", 1, o, e); end
    bus.d_req = 1'b0; bus.d_wr = 1'b0;
    @(negedge clk); #1;
    o = snap(); vectors++;
    if (o !== snap_t'(0)) begin miscompares++; show_fail("d_write_idle", 2, o, '0); end
  endtask

  task automatic test_conflict();
    snap_t o, e;
    do_reset();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 16'h1000;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h4568; #1;
    o = snap(); vectors++;
    if (o !== snap_t'(0)) begin miscompares++; show_fail("conflict_accept", 0, o, '0); end
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk); #1;
      o = snap();
      if (c <= 12)      e = exp_fill(1'b0, 16'h1000, c);
      else if (c == 13) e = '0;
      else if (c <= 25) e = exp_fill(1'b1, 16'h4560, c - 13);
      else              e = '0;
      vectors++;
      if (o !== e) begin miscompares++; show_fail("conflict", c, o, e); end
      if (c == 12) bus.i_req = 1'b0;
      if (c == 25) bus.d_req = 1'b0;
    end
  endtask

  task automatic test_d_fill_i_pending();
    snap_t o, e;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h7770; #1;
    o = snap(); vectors++;
    if (o !== snap_t'(0)) begin miscompares++; show_fail("pending_accept", 0, o, '0); end
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk); #1;
      o = snap();
      if (c <= 12)      e = exp_fill(1'b1, 16'h7770, c);
      else if (c == 13) e = '0;
      else if (c <= 25) e = exp_fill(1'b0, 16'h5550, c - 13);
      else              e = '0;
      vectors++;
      if (o !== e) begin miscompares++; show_fail("d_fill_i_pending", c, o, e); end
      if (c == 3) begin bus.i_req = 1'b1; bus.i_addr = 16'h5550; end
      if (c == 12) bus.d_req = 1'b0;
      if (c == 25) bus.i_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_fill();
    snap_t o, e;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 16'h6666;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      o = snap(); e = exp_fill(1'b0, 16'h6660, c); vectors++;
      if (o !== e) begin miscompares++; show_fail("mid_reset_fill", c, o, e); end
    end
    // Reset lands on the edge after beat 3; returns still in flight arrive stale.
    rst_n = 1'b0; bus.i_req = 1'b0;
    for (int c = 9; c <= 13; c++) begin
      @(negedge clk); #1;
      o = snap(); o.rdata = '0; vectors++;
      if (o !== snap_t'(0)) begin miscompares++; show_fail("mid_reset_after", c, o, '0); end
      rst_n = 1'b1;
    end
  endtask

  task automatic test_d_drop();
    snap_t o, e;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0100; #1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk); #1;
      o = snap(); e = (c <= 12) ? exp_fill(1'b1, 16'h0100, c) : snap_t'(0); vectors++;
      if (o !== e) begin miscompares++; show_fail("d_drop", c, o, e); end
      if (c == 7) bus.d_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_rr_d_first();
    test_d_write();
    test_conflict();
    test_d_fill_i_pending();
    test_reset_mid_fill();
    test_d_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at vector %0d", vectors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
